// File: rtl/fetch_pkg.sv
// Shared defaults and helpers for the instruction fetch arbiter.
package fetch_pkg;
  localparam int DEF_CORES  = 2;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  // Round-robin pointer width; a single core still gets a 1-bit pointer.
  function automatic int ptr_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin select: first eligible core at or after rr_ptr.
module rr_picker
  import fetch_pkg::*;
#(
  parameter int CORES = DEF_CORES,
  parameter int PTR_W = ptr_w(CORES)
) (
  input  logic [CORES-1:0] eligible,
  input  logic [PTR_W-1:0] rr_ptr,
  output logic [CORES-1:0] grant,
  output logic [PTR_W-1:0] grant_idx,
  output logic             any_grant
);
  always_comb begin
    int idx;
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    idx       = 0;
    for (int k = 0; k < CORES; k++) begin
      idx = (int'(rr_ptr) + k) % CORES;
      if (!any_grant && eligible[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = PTR_W'(idx);
        any_grant  = 1'b1;
      end
    end
  end
endmodule

// File: rtl/fetch_arbiter.sv
// Shares one instruction memory read port among CORES fetch requesters,
// round-robin, one grant per cycle, ack exactly one cycle after grant.
module fetch_arbiter
  import fetch_pkg::*;
#(
  parameter int CORES  = DEF_CORES,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [CORES-1:0]        req,
  input  logic [CORES*ADDR_W-1:0] addr,
  output logic [ADDR_W-1:0]       mem_address,
  input  logic [DATA_W-1:0]       mem_dataOut,
  output logic [CORES-1:0]        ack,
  output logic [DATA_W-1:0]       fetch_data,
  output logic                    busy
);
  localparam int PTR_W = ptr_w(CORES);

  logic [CORES-1:0][ADDR_W-1:0] addr_arr;
  logic [CORES-1:0]             inflight_mask;
  logic [CORES-1:0]             eligible;
  logic [CORES-1:0]             grant;
  logic [PTR_W-1:0]             rr_ptr;
  logic [PTR_W-1:0]             grant_idx;
  logic                         any_grant;
  logic                         take;
  logic [ADDR_W-1:0]            addr_q;
  logic [DATA_W-1:0]            data_q;

  assign addr_arr = addr;

  // The core whose read is in flight cannot be regranted this cycle.
  assign eligible = req & ~inflight_mask;

  rr_picker #(.CORES(CORES), .PTR_W(PTR_W)) u_pick (
    .eligible  (eligible),
    .rr_ptr    (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_grant (any_grant)
  );

  // A grant during reset is discarded, so the address bus stays at zero too.
  assign take        = any_grant & ~reset;
  assign mem_address = reset ? '0 : (take ? addr_arr[grant_idx] : addr_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr        <= '0;
      inflight_mask <= '0;
      addr_q        <= '0;
      data_q        <= '0;
    end else begin
      inflight_mask <= take ? grant : '0;
      if (take) begin
        addr_q <= addr_arr[grant_idx];
        rr_ptr <= (grant_idx == PTR_W'(CORES - 1)) ? '0 : grant_idx + PTR_W'(1);
      end
      if (busy) data_q <= mem_dataOut;
    end
  end

  // Memory data is passed straight through in the ack cycle, held afterwards.
  assign ack        = inflight_mask;
  assign busy       = |inflight_mask;
  assign fetch_data = busy ? mem_dataOut : data_q;
endmodule

// File: doc/fetch_arbiter.md
FETCH_ARBITER -- requirements
Module: fetch_arbiter

Interface
REQ-001 Parameter CORES, default 2, number of core fetch requesters sharing one instruction memory read port.
REQ-002 Parameter ADDR_W, default 32, instruction address width.
REQ-003 Parameter DATA_W, default 32, instruction word width.
REQ-004 The block SHALL use one clock and a synchronous active-high reset, as ports clk and reset.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 req  input  CORES  per-core fetch request, bit i = core i.
REQ-008 addr  input  CORES*ADDR_W  per-core fetch address, core i in bits [i*ADDR_W +: ADDR_W].
REQ-009 mem_address  output  ADDR_W  address driven to the instruction memory.
REQ-010 mem_dataOut  input  DATA_W  instruction memory read data, valid one cycle after address is sampled.
REQ-011 ack  output  CORES  one-hot response strobe; bit i high = mem_dataOut-derived word for core i is on fetch_data.
REQ-012 fetch_data  output  DATA_W  instruction word returned to the acked core.
REQ-013 busy  output  1  high while a read is in flight.

Function
REQ-014 The block SHALL pick at most one requester per cycle using round-robin priority starting at pointer rr_ptr.
REQ-015 Eligible set in cycle T SHALL be req & ~inflight_mask, where inflight_mask is one-hot for the core granted in T-1 (zero if none).
REQ-016 On grant of core g in cycle T, mem_address SHALL equal addr[g] combinationally in T; rr_ptr SHALL become (g+1) mod CORES at the T->T+1 edge.
REQ-017 With no eligible requester, rr_ptr SHALL hold and mem_address SHALL hold its previous value.
REQ-018 In cycle T+1, ack[g] SHALL be 1 (single cycle), fetch_data SHALL equal mem_dataOut, and busy SHALL be 1.
REQ-019 Latency SHALL be exactly one cycle from grant to ack; throughput one grant per cycle when two or more cores request.
REQ-020 A requester SHALL hold req and addr stable until its ack; req still high in the cycle after ack is a new request.
REQ-021 Because of REQ-015, the same core SHALL NOT receive grants in consecutive cycles; a lone requester is served every other cycle.
REQ-022 A request dropped before grant SHALL be ignored without error; a request dropped after grant SHALL still be acked.
REQ-023 Simultaneous requests from all cores SHALL be served in order rr_ptr, rr_ptr+1, ... with no core waiting more than CORES grants.
REQ-024 ack SHALL never have more than one bit set.
REQ-025 CORES=1 SHALL be legal: grants alternate with ack cycles.

Reset
REQ-026 While reset is high at a rising edge: rr_ptr=0, inflight_mask=0, ack=0, busy=0, fetch_data=0, mem_address=0.
REQ-027 A read granted in the cycle reset is asserted SHALL be discarded: no ack in the following cycle.
REQ-028 First grant after reset deasserts SHALL follow REQ-014 with rr_ptr=0.

Structure
REQ-029 A shared package fetch_pkg SHALL hold default CORES, ADDR_W, DATA_W and the function computing log2(CORES) for rr_ptr width.
REQ-030 One sub-module rr_picker SHALL implement the combinational round-robin select (inputs eligible, rr_ptr; outputs one-hot grant, grant index, any_grant).
REQ-031 All state (rr_ptr, inflight index, inflight valid, fetch_data) SHALL reside in fetch_arbiter; memory is external.

Verification
REQ-032 Reset: assert reset with req=2'b11 for 2 cycles -> ack=0, busy=0, mem_address=0 throughout; no ack in the cycle after reset drops unless granted.
REQ-033 Single core: core0 req, addr=0x4, memory word 0x8C010004 -> grant T, ack=2'b01 and fetch_data=0x8C010004 at T+1; held req regranted at T+2.
REQ-034 Contention: CORES=2, both req from reset, addr0=0x0, addr1=0x1 -> grants 0,1,0,1 on consecutive cycles; acks 01,10,01,10 one cycle later.
REQ-035 Fairness: CORES=4, all req high 12 cycles -> each core acked exactly 3 times, no gap between acks for any core over 4 grants.
REQ-036 Drop: core1 drops req the cycle it is granted -> ack[1] still pulses next cycle; a request dropped before grant never acked.
REQ-037 Mid-flight reset: assert reset in the ack cycle of core0 -> ack cleared at next edge, rr_ptr=0, next grant goes to core0 if requesting.
